// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU memory
// initiator and the word-addressed RAM responder.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding RAM responder with fixed wait states,
// read-before-write responses and out-of-range error flagging.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0] LP_WAIT_INIT =
        4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    // With zero wait states RESP is entered on the accept edge itself,
    // before the latches are loaded, so the live request is used then.
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0))
                       || ((r_state == ST_WAIT) && (r_cnt == 4'd0));
    assign w_write = (r_state == ST_IDLE) ? bus.req_write : r_write;
    assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;
    assign w_in_range = {1'b0, w_addr} < LP_DEPTH;

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latches, wait counter and response registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= LP_WAIT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_in_range ? r_mem[w_addr] : '0;
                r_err   <= !w_in_range;
            end else if (r_state == ST_RESP) begin
                r_err <= 1'b0;
            end
        end
    end

    // RAM write port; old contents are captured above on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_enter_resp && w_write && w_in_range) begin
            r_mem[w_addr] <= w_wdata;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (1, 0 and 3 wait states) driven in
// turn, with a scoreboard queue and a small RAM model.
module tb_mem_responder;
    typedef struct {
        int          u;
        logic [15:0] rd;
        bit          rd_dc;
        bit          err;
        int          cyc;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        v   [3];
    logic        w   [3];
    logic [9:0]  ad  [3];
    logic [15:0] wd  [3];
    logic        rdy [3];
    logic        rv  [3];
    logic        re  [3];
    logic        bsy [3];
    logic [15:0] rd  [3];
    bit          pv  [3];

    int          wcs [3] = '{1, 0, 3};
    int          dep [3] = '{1000, 1024, 1024};
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    sb_t         sbq [$];
    logic [15:0] mdl [int];

    mem_responder_if if0 ();
    mem_responder_if if1 ();
    mem_responder_if if2 ();

    mem_responder #(.DEPTH(1000), .WAIT_CYCLES(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if0)
    );
    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if1)
    );
    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if2)
    );

    assign if0.req_valid = v[0];
    assign if0.req_write = w[0];
    assign if0.req_addr  = ad[0];
    assign if0.req_wdata = wd[0];
    assign rdy[0] = if0.req_ready;
    assign rv[0]  = if0.rsp_valid;
    assign re[0]  = if0.rsp_err;
    assign bsy[0] = if0.busy;
    assign rd[0]  = if0.rsp_rdata;

    assign if1.req_valid = v[1];
    assign if1.req_write = w[1];
    assign if1.req_addr  = ad[1];
    assign if1.req_wdata = wd[1];
    assign rdy[1] = if1.req_ready;
    assign rv[1]  = if1.rsp_valid;
    assign re[1]  = if1.rsp_err;
    assign bsy[1] = if1.busy;
    assign rd[1]  = if1.rsp_rdata;

    assign if2.req_valid = v[2];
    assign if2.req_write = w[2];
    assign if2.req_addr  = ad[2];
    assign if2.req_wdata = wd[2];
    assign rdy[2] = if2.req_ready;
    assign rv[2]  = if2.rsp_valid;
    assign re[2]  = if2.rsp_err;
    assign bsy[2] = if2.busy;
    assign rd[2]  = if2.rsp_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    always @(posedge clk) begin
        sb_t e;
        #1;
        for (int u = 0; u < 3; u++) begin
            if (rv[u]) begin
                if (sbq.size() == 0 || sbq[0].u != u) begin
                    chk("unexp_rsp", 32'(u), 32'hFF);
                end else begin
                    e = sbq.pop_front();
                    if (!e.rd_dc) chk("rdata", 32'(rd[u]), 32'(e.rd));
                    chk("err", 32'(re[u]), 32'(e.err));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (pv[u]) begin
                chk("err_clr", 32'(re[u]), 32'd0);
                chk("pulse_1cyc", 32'(rv[u]), 32'd0);
            end
            pv[u] = rv[u];
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            chk("timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic wait_ready(input int u);
        int t;
        t = 0;
        while (!rdy[u] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready", 32'(rdy[u]), 32'd1);
    endtask

    // Push the model's expectation, then present one request.
    task automatic push_exp(input int u, input bit wr,
                            input logic [9:0] a, input logic [15:0] d);
        sb_t e;
        int  k;
        k = u * 4096 + int'(a);
        e.u = u;
        e.err = (int'(a) >= dep[u]);
        e.rd = 16'h0;
        e.rd_dc = 1'b0;
        if (!e.err) begin
            if (mdl.exists(k)) e.rd = mdl[k];
            else e.rd_dc = 1'b1;
            if (wr) mdl[k] = d;
        end
        e.cyc = cyc + 1 + wcs[u];
        sbq.push_back(e);
    endtask

    task automatic do_req(input int u, input bit wr,
                          input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        wait_ready(u);
        push_exp(u, wr, a, d);
        v[u] = 1'b1;
        w[u] = wr;
        ad[u] = a;
        wd[u] = d;
        @(negedge clk);
        v[u] = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            v[u] = 1'b0;
            w[u] = 1'b0;
            ad[u] = '0;
            wd[u] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int u = 0; u < 3; u++) begin
            chk("rst_ready", 32'(rdy[u]), 32'd1);
            chk("rst_busy", 32'(bsy[u]), 32'd0);
            chk("rst_valid", 32'(rv[u]), 32'd0);
            chk("rst_rdata", 32'(rd[u]), 32'd0);
        end

        do_req(0, 1'b1, 10'h005, 16'hBEEF);
        do_req(0, 1'b0, 10'h005, 16'h0000);
        do_req(0, 1'b1, 10'h010, 16'h1234);
        do_req(0, 1'b1, 10'h010, 16'h5678);
        do_req(0, 1'b0, 10'h010, 16'h0000);
        do_req(0, 1'b1, 10'd999, 16'h3333);
        do_req(0, 1'b1, 10'd1000, 16'hAAAA);
        do_req(0, 1'b0, 10'd999, 16'h0000);
        do_req(0, 1'b0, 10'd1023, 16'h0000);

        do_req(1, 1'b1, 10'h007, 16'h0707);
        do_req(1, 1'b0, 10'h007, 16'h0000);
        do_req(1, 1'b1, 10'h3FF, 16'h1023);
        do_req(1, 1'b0, 10'h3FF, 16'h0000);

        do_req(2, 1'b1, 10'h3FF, 16'h7777);
        do_req(2, 1'b1, 10'h005, 16'h4242);

        // Request inputs change during WAIT and must be neither used
        // nor queued.
        @(negedge clk);
        wait_ready(2);
        push_exp(2, 1'b0, 10'h005, 16'h0000);
        v[2] = 1'b1;
        w[2] = 1'b0;
        ad[2] = 10'h005;
        @(negedge clk);
        v[2] = 1'b0;
        @(negedge clk);
        v[2] = 1'b1;
        w[2] = 1'b1;
        ad[2] = 10'h3FF;
        wd[2] = 16'hDEAD;
        @(negedge clk);
        v[2] = 1'b0;
        wait_drain();
        repeat (5) begin
            @(negedge clk);
            chk("no_queue_valid", 32'(rv[2]), 32'd0);
            chk("no_queue_busy", 32'(bsy[2]), 32'd0);
        end
        do_req(2, 1'b0, 10'h3FF, 16'h0000);

        // Reset while in WAIT aborts the write.
        do_req(2, 1'b1, 10'h020, 16'h1111);
        @(negedge clk);
        wait_ready(2);
        v[2] = 1'b1;
        w[2] = 1'b1;
        ad[2] = 10'h020;
        wd[2] = 16'h0F0F;
        @(negedge clk);
        v[2] = 1'b0;
        chk("mid_busy", 32'(bsy[2]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(bsy[2]), 32'd0);
        chk("abort_ready", 32'(rdy[2]), 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("abort_novalid", 32'(rv[2]), 32'd0);
        end
        do_req(2, 1'b0, 10'h020, 16'h0000);

        wait_drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
